// File: rtl/mipi_lane_deskew.sv
// mipi_lane_deskew: per-lane FIFOs that absorb inter-lane skew and emit lane-aligned words
module mipi_lane_deskew #(
    parameter int LANE_NUM   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_SKEW   = 4
) (
    input  logic                    I_CLK,
    input  logic                    I_Rst_n,
    input  logic [8*LANE_NUM-1:0]   I_Lane_Data,
    input  logic [LANE_NUM-1:0]     I_Lane_Vaild,
    input  logic                    I_Packet_done,
    output logic [8*LANE_NUM-1:0]   O_Deskew_Data,
    output logic                    O_Deskew_Vaild,
    output logic                    O_ReSearch_Offset,
    output logic [3:0]              O_Lane_Skew
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_ALL   = 3'd1,
        STREAM     = 3'd2,
        ERROR      = 3'd3,
        DRAIN_WAIT = 3'd4
    } state_t;

    state_t                  state;
    logic [7:0]              skew_cnt;
    logic [LANE_NUM-1:0]     empty;
    logic [LANE_NUM-1:0]     ovf;
    logic [8*LANE_NUM-1:0]   head;
    logic                    accept;
    logic                    rd_en;
    logic                    flush;
    logic                    skew_err;
    logic                    no_valid;

    assign no_valid = I_Lane_Vaild == '0;
    assign accept   = state != ERROR && state != DRAIN_WAIT;
    assign rd_en    = state == STREAM && !(|empty);
    assign skew_err = state == WAIT_ALL && (|empty) && skew_cnt == 8'(MAX_SKEW);
    assign flush    = I_Packet_done || state == ERROR || (state == STREAM && no_valid && (|empty));

    for (genvar g = 0; g < LANE_NUM; g++) begin : g_lane
        logic [7:0]  mem [FIFO_DEPTH];
        logic [AW-1:0] wp;
        logic [AW-1:0] rp;
        logic [AW:0]   cnt;
        logic          full;
        logic          wr;
        assign full     = cnt == (AW+1)'(FIFO_DEPTH);
        // a pop in the same cycle frees a slot, so a full FIFO may still accept
        assign wr       = I_Lane_Vaild[g] && accept && !flush && (!full || rd_en);
        assign ovf[g]   = I_Lane_Vaild[g] && accept && full && !rd_en;
        assign empty[g] = cnt == '0;
        assign head[8*g +: 8] = mem[rp];
        // byte storage, no reset needed
        always_ff @(posedge I_CLK) begin
            if (wr)
                mem[wp] <= I_Lane_Data[8*g +: 8];
        end
        // pointers and occupancy; flush zeroes everything at once
        always_ff @(posedge I_CLK or negedge I_Rst_n) begin
            if (!I_Rst_n) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else if (flush) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                wp  <= wr ? wp + 1'b1 : wp;
                rp  <= rd_en ? rp + 1'b1 : rp;
                cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd_en);
            end
        end
    end

    // control FSM with registered outputs; packet-done beats any error
    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            state             <= IDLE;
            skew_cnt          <= '0;
            O_Deskew_Data     <= '0;
            O_Deskew_Vaild    <= 1'b0;
            O_ReSearch_Offset <= 1'b0;
            O_Lane_Skew       <= '0;
        end else begin
            O_ReSearch_Offset <= 1'b0;
            O_Deskew_Vaild    <= rd_en && !flush;
            if (rd_en)
                O_Deskew_Data <= head;
            if (I_Packet_done) begin
                state <= IDLE;
            end else if ((|ovf) || skew_err) begin
                state             <= ERROR;
                O_ReSearch_Offset <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (!no_valid) begin
                            state    <= WAIT_ALL;
                            skew_cnt <= '0;
                        end
                    end
                    WAIT_ALL: begin
                        if (!(|empty)) begin
                            state       <= STREAM;
                            O_Lane_Skew <= skew_cnt > 8'd15 ? 4'd15 : skew_cnt[3:0];
                        end else begin
                            skew_cnt <= skew_cnt + 8'd1;
                        end
                    end
                    STREAM:     state <= (no_valid && (|empty)) ? IDLE : STREAM;
                    ERROR:      state <= DRAIN_WAIT;
                    DRAIN_WAIT: state <= no_valid ? IDLE : DRAIN_WAIT;
                    default:    state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mipi_lane_deskew.sv
// tb_mipi_lane_deskew: directed checks of skew absorption, error, flush and reset behaviour
module tb_mipi_lane_deskew;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] lane_data;
    logic [1:0]  lane_valid;
    logic        packet_done;
    logic [15:0] dd;
    logic        dv;
    logic        rs;
    logic [3:0]  sk;
    logic [15:0] odd;
    logic        odv;
    logic        ors;
    logic [3:0]  osk;

    int total = 0;
    int bad = 0;
    int first_v, first_d, nwords, derr, rs_cnt, rs_first, ors_first;
    int st_log [64];
    int ost_log [64];
    int v_log [64];
    int e_log [64];

    always #5 clk = ~clk;

    mipi_lane_deskew #(.LANE_NUM(2), .FIFO_DEPTH(8), .MAX_SKEW(4)) dut (
        .I_CLK(clk), .I_Rst_n(rst_n), .I_Lane_Data(lane_data), .I_Lane_Vaild(lane_valid),
        .I_Packet_done(packet_done), .O_Deskew_Data(dd), .O_Deskew_Vaild(dv),
        .O_ReSearch_Offset(rs), .O_Lane_Skew(sk)
    );

    // skew tolerance pushed past the depth so only overflow can trip ERROR
    mipi_lane_deskew #(.LANE_NUM(2), .FIFO_DEPTH(8), .MAX_SKEW(12)) dut_ovf (
        .I_CLK(clk), .I_Rst_n(rst_n), .I_Lane_Data(lane_data), .I_Lane_Vaild(lane_valid),
        .I_Packet_done(packet_done), .O_Deskew_Data(odd), .O_Deskew_Vaild(odv),
        .O_ReSearch_Offset(ors), .O_Lane_Skew(osk)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // lane0 valid on cycles [s0,s0+len), lane1 on [s1,s1+len); pd = packet-done cycle, rc = reset cycle
    task automatic play(input int s0, input int s1, input int len, input int pd, input int rc, input int n);
        first_v = -1; first_d = 0; nwords = 0; derr = 0; rs_cnt = 0; rs_first = -1; ors_first = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            st_log[k]  = int'(dut.state);
            ost_log[k] = int'(dut_ovf.state);
            v_log[k]   = int'(dv);
            e_log[k]   = int'(dut.empty);
            if (dv) begin
                if (first_v < 0) begin
                    first_v = k;
                    first_d = int'(dd);
                end
                if (dd !== {8'(32'h20 + nwords), 8'(32'h10 + nwords)})
                    derr++;
                nwords++;
            end
            if (rs) begin
                rs_cnt++;
                if (rs_first < 0) rs_first = k;
            end
            if (ors && ors_first < 0) ors_first = k;
            lane_valid[0] = k >= s0 && k < s0 + len;
            lane_valid[1] = k >= s1 && k < s1 + len;
            lane_data     = {8'(32'h20 + k - s1), 8'(32'h10 + k - s0)};
            packet_done   = k == pd;
            if (k == rc) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_async_vld", int'(dv), 0);
                check("rst_async_data", int'(dd), 0);
                check("rst_async_rs", int'(rs), 0);
                check("rst_async_skew", int'(sk), 0);
                check("rst_async_state", int'(dut.state), 0);
                #1 rst_n = 1'b1;
            end
        end
        lane_valid  = '0;
        packet_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; lane_data = '0; lane_valid = '0; packet_done = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_vld", int'(dv), 0);
        check("reset_data", int'(dd), 0);
        check("reset_rs", int'(rs), 0);
        check("reset_skew", int'(sk), 0);
        check("reset_state", int'(dut.state), 0);
        check("reset_empty", int'(dut.empty), 3);
        rst_n = 1'b1;

        play(0, 0, 16, -1, -1, 24);
        check("s0_first_cycle", first_v, 3);
        check("s0_first_word", first_d, 16'h2010);
        check("s0_words", nwords, 16);
        check("s0_order", derr, 0);
        check("s0_skew", int'(sk), 0);
        check("s0_no_rs", rs_cnt, 0);
        check("s0_stream_tail", st_log[18], 2);
        check("s0_idle", st_log[19], 0);

        play(0, 2, 16, -1, -1, 28);
        check("s2_first_cycle", first_v, 5);
        check("s2_first_word", first_d, 16'h2010);
        check("s2_words", nwords, 16);
        check("s2_order", derr, 0);
        check("s2_skew", int'(sk), 2);
        check("s2_stream_tail", st_log[20], 2);
        check("s2_idle", st_log[21], 0);

        play(0, 4, 16, -1, -1, 30);
        check("s4_first_cycle", first_v, 7);
        check("s4_words", nwords, 16);
        check("s4_order", derr, 0);
        check("s4_skew", int'(sk), 4);
        check("s4_no_rs", rs_cnt, 0);

        play(0, 7, 16, -1, -1, 30);
        check("s7_rs_count", rs_cnt, 1);
        check("s7_rs_cycle", rs_first, 6);
        check("s7_error_state", st_log[6], 3);
        check("s7_drain_first", st_log[7], 4);
        check("s7_drain_last", st_log[23], 4);
        check("s7_idle", st_log[24], 0);
        check("s7_no_words", nwords, 0);

        play(0, 99, 20, -1, -1, 28);
        check("ovf_wait_before", ost_log[8], 1);
        check("ovf_error_state", ost_log[9], 3);
        check("ovf_rs_cycle", ors_first, 9);
        check("ovf_drain", ost_log[10], 4);
        check("ovf_idle", ost_log[21], 0);
        check("ovf_main_skew_err", rs_first, 6);

        play(0, 0, 16, 8, -1, 26);
        check("pd_vld_before", v_log[8], 1);
        check("pd_vld_after", v_log[9], 0);
        check("pd_state_idle", st_log[9], 0);
        check("pd_fifos_empty", e_log[9], 3);
        check("pd_no_rs", rs_cnt, 0);
        check("pd_restart_vld", v_log[12], 1);

        play(0, 0, 6, -1, 6, 14);
        check("rr_vld_before", v_log[6], 1);
        check("rr_vld_after", v_log[8], 0);
        check("rr_idle", st_log[10], 0);
        check("rr_no_rs", rs_cnt, 0);

        play(0, 0, 16, -1, -1, 24);
        check("rr_resume_first", first_v, 3);
        check("rr_resume_words", nwords, 16);
        check("rr_resume_order", derr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mipi_lane_deskew.md
MIPI_LANE_DESKEW -- requirements
Module: mipi_lane_deskew

Interface
REQ-001 SHALL have parameter LANE_NUM, default 2: number of lanes; legal values 1, 2, 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: per-lane FIFO depth; a power of 2, from 4 to 16.
REQ-003 SHALL have parameter MAX_SKEW, default 4: maximum tolerated inter-lane skew in cycles; must be at most FIFO_DEPTH-3.
REQ-004 SHALL have port I_CLK, input, 1: byte clock. One clock only; all logic on the rising edge.
REQ-005 SHALL have port I_Rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port I_Lane_Data, input, 8*LANE_NUM: byte-aligned lane data; lane i occupies bits [8i+7:8i].
REQ-007 SHALL have port I_Lane_Vaild, input, LANE_NUM: per-lane byte-valid from the byte aligners.
REQ-008 SHALL have port I_Packet_done, input, 1: one-cycle end-of-packet pulse from the unpacker.
REQ-009 SHALL have port O_Deskew_Data, output, 8*LANE_NUM: lane-aligned word, in the same lane order as the input.
REQ-010 SHALL have port O_Deskew_Vaild, output, 1: O_Deskew_Data is valid.
REQ-011 SHALL have port O_ReSearch_Offset, output, 1: one-cycle request telling the byte aligners to re-hunt.
REQ-012 SHALL have port O_Lane_Skew, output, 4: last measured skew, in cycles.

Function
REQ-013 SHALL have one FIFO per lane; lane i's byte is written in any cycle where I_Lane_Vaild[i]=1 and the state is not ERROR or DRAIN_WAIT.
REQ-014 SHALL implement a state machine with states IDLE, WAIT_ALL, STREAM, ERROR and DRAIN_WAIT.
REQ-015 IDLE: any I_Lane_Vaild bit high SHALL move to WAIT_ALL on the next cycle and clear the skew counter to 0.
REQ-016 WAIT_ALL: if all FIFOs are non-empty, SHALL go to STREAM and latch O_Lane_Skew = counter; otherwise SHALL increment the counter.
REQ-017 WAIT_ALL: if the counter equals MAX_SKEW and some FIFO is still empty, SHALL go to ERROR.
REQ-018 STREAM: the read enable SHALL equal "all FIFOs non-empty", popping every lane together.
REQ-019 STREAM output: O_Deskew_Data and O_Deskew_Vaild SHALL be registered, appearing 1 cycle after the read.
REQ-020 End-to-end latency SHALL be as follows: all lanes valid together at cycle t gives the first O_Deskew_Vaild at t+3; for skew s, at t+3+s.
REQ-021 STREAM: when all I_Lane_Vaild=0 and any FIFO is empty, SHALL flush all FIFOs and go to IDLE.
REQ-022 A write to a full FIFO, in any state, SHALL go to ERROR; the byte is discarded.
REQ-023 ERROR SHALL last exactly one cycle: pulse O_ReSearch_Offset=1, flush all FIFOs, then go to DRAIN_WAIT.
REQ-024 DRAIN_WAIT SHALL ignore writes and return to IDLE in the cycle after all I_Lane_Vaild=0.
REQ-025 I_Packet_done=1 in any state SHALL flush all FIFOs and force IDLE on the next cycle, with no O_ReSearch_Offset pulse.
REQ-026 When I_Packet_done and an overflow or skew error occur in the same cycle, I_Packet_done SHALL take priority.
REQ-027 A flush SHALL zero the read/write pointers and counts in the same cycle; O_Deskew_Vaild SHALL be 0 in the cycle after the flush.
REQ-028 With LANE_NUM=1, WAIT_ALL SHALL always exit with skew 0, and the ERROR path SHALL be reachable only through overflow.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; each count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-030 Simultaneous write and read on a full FIFO SHALL be legal and SHALL NOT count as overflow.
REQ-031 O_Lane_Skew SHALL saturate at 15.

Reset
REQ-032 I_Rst_n=0 SHALL, asynchronously, set: state IDLE; every FIFO empty; O_Deskew_Data=0; O_Deskew_Vaild=0; O_ReSearch_Offset=0; O_Lane_Skew=0; skew counter 0.
REQ-033 Reset asserted mid-STREAM SHALL drop O_Deskew_Vaild immediately; after release the block SHALL wait in IDLE for fresh valids.

Verification
REQ-034 SHALL cover zero skew: LANE_NUM=2; lanes 0 and 1 both valid from cycle 0 carrying 0x10..0x1F and 0x20..0x2F. Required: O_Deskew_Vaild first at cycle 3 with data 0x2010; 16 words; O_Lane_Skew=0.
REQ-035 SHALL cover skew 2: the same data with lane 1 starting at cycle 2. Required: first word 0x2010 at cycle 5; O_Lane_Skew=2; no byte lost; IDLE after both valids fall.
REQ-036 SHALL cover excess skew: MAX_SKEW=4 and lane 1 delayed 7 cycles. Required: a single O_ReSearch_Offset pulse, no O_Deskew_Vaild, then DRAIN_WAIT until both valids are 0.
REQ-037 SHALL cover overflow: lane 0 streaming and lane 1 never valid, with MAX_SKEW raised past FIFO_DEPTH via a forced test configuration. Required: ERROR on the 9th write to lane 0's FIFO (depth 8).
REQ-038 SHALL cover packet done: I_Packet_done pulsed mid-STREAM. Required: O_Deskew_Vaild=0 one cycle later; FIFOs empty; no O_ReSearch_Offset pulse.
REQ-039 SHALL cover async reset: reset asserted at an arbitrary mid-STREAM cycle. Required: all outputs 0 within the same cycle; normal streaming resumes on the next packet.
